// File: rtl/r2sdf_bf_stage.sv
// -----------------------------------------------------------------------------
// r2sdf_bf_stage
//
// One radix-2 single-delay-feedback (decimation-in-frequency) butterfly stage of
// a 2^N-point streaming complex FFT. One complex sample enters every clock; N
// instances chained stage 1..N (start_op -> start_ip) form the complete FFT.
//
// A frame at this stage is 2D samples, D = 2^(N-STAGE). During the first half
// (fill phase) new samples go into a D-deep complex delay line while the
// previous frame's differences come out of it, rotated by the twiddle factor.
// During the second half (butterfly phase) the delayed sample and the current
// one are summed to the output and their difference goes back into the delay.
//
// Ports
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset
//   start_ip  pulse marking the first sample of an input frame
//   ip_re/im  input sample, DW-bit signed
//   tw_idx    twiddle ROM address (combinational from the sample counter)
//   tw_re/im  cos / -sin for tw_idx, TW-bit signed, 1.0 = 2^(TW-2)
//   op_re/im  registered output sample
//   start_op  registered, high with the first output sample of a frame
//   op_idx    registered bit-reversed output position (frequency bin at STAGE=N)
// -----------------------------------------------------------------------------
module r2sdf_bf_stage #(
  parameter int N     = 3,
  parameter int STAGE = 1,
  parameter int DW    = 16,
  parameter int TW    = 16,
  localparam int D    = 1 << (N - STAGE),
  localparam int CW   = N - STAGE + 1,
  localparam int TIW  = (N > 1) ? N - 1 : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_ip,
  input  logic signed [DW-1:0] ip_re,
  input  logic signed [DW-1:0] ip_im,
  output logic [TIW-1:0]       tw_idx,
  input  logic signed [TW-1:0] tw_re,
  input  logic signed [TW-1:0] tw_im,
  output logic signed [DW-1:0] op_re,
  output logic signed [DW-1:0] op_im,
  output logic                 start_op,
  output logic [N-1:0]         op_idx
);

  // Full-precision product width: DW x TW signed plus one bit for the add.
  localparam int PW = DW + TW + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                 running_q, running_d;
  logic [CW-1:0]        cnt_q, cnt_d;       // position within the 2D-sample frame
  logic                 pend_q, pend_d;     // a start is waiting to reach the output
  logic [N-1:0]         p_q, p_d;           // output position within the 2^N frame
  logic signed [DW-1:0] dl_re_q [D];
  logic signed [DW-1:0] dl_im_q [D];
  logic signed [DW-1:0] op_re_q, op_re_d;
  logic signed [DW-1:0] op_im_q, op_im_d;
  logic                 start_op_q, start_op_d;
  logic [N-1:0]         op_idx_q, op_idx_d;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic                 active;
  logic                 fill;
  logic [CW-1:0]        cnt_eff;
  logic signed [DW-1:0] f_re, f_im;
  logic signed [PW-1:0] prod_re, prod_im;
  logic signed [DW-1:0] mul_re, mul_im;

  always_comb begin
    // A start pulse both enables the stage and forces this sample to be cnt=0.
    active  = running_q | start_ip;
    cnt_eff = start_ip ? '0 : cnt_q;
    // D is a power of two, so cnt < D is simply "counter MSB clear".
    fill    = ~cnt_eff[CW-1];
    tw_idx  = fill ? (TIW'(cnt_eff) << (STAGE - 1)) : '0;

    // Oldest delay entry.
    f_re = dl_re_q[D-1];
    f_im = dl_im_q[D-1];

    prod_re = PW'(f_re) * PW'(tw_re) - PW'(f_im) * PW'(tw_im);
    prod_im = PW'(f_re) * PW'(tw_im) + PW'(f_im) * PW'(tw_re);
    // Arithmetic shift floors; the cast keeps the low DW bits.
    mul_re  = DW'(prod_re >>> (TW - 2));
    mul_im  = DW'(prod_im >>> (TW - 2));
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  logic signed [DW-1:0] push_re, push_im;
  logic [N-1:0]         pidx;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    running_d  = running_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    p_d        = p_q;
    op_re_d    = '0;
    op_im_d    = '0;
    start_op_d = 1'b0;
    op_idx_d   = '0;
    push_re    = ip_re;
    push_im    = ip_im;
    pidx       = p_q;

    if (active) begin
      running_d  = 1'b1;
      cnt_d      = cnt_eff + 1'b1;
      // The first butterfly output after a start is the first sample of the
      // output frame; later wraps of the counter do not re-announce it.
      start_op_d = (pend_q | start_ip) & (cnt_eff == CW'(D));
      pend_d     = (pend_q | start_ip) & ~start_op_d;

      pidx = start_op_d ? '0 : p_q;
      p_d  = pidx + 1'b1;
      for (int i = 0; i < N; i++) begin
        op_idx_d[i] = pidx[N-1-i];
      end

      if (fill) begin
        op_re_d = mul_re;
        op_im_d = mul_im;
      end else begin
        op_re_d = f_re + ip_re;
        op_im_d = f_im + ip_im;
        push_re = f_re - ip_re;
        push_im = f_im - ip_im;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      running_q  <= 1'b0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      p_q        <= '0;
      op_re_q    <= '0;
      op_im_q    <= '0;
      start_op_q <= 1'b0;
      op_idx_q   <= '0;
      // NOTE: the delay line is cleared on reset because the first frame's
      // fill-phase outputs read it; this keeps it in flops rather than RAM.
      for (int i = 0; i < D; i++) begin
        dl_re_q[i] <= '0;
        dl_im_q[i] <= '0;
      end
    end else begin
      // NOTE: all state uses non-blocking assignment so every register sees
      // the pre-edge values, which is what makes the shift below correct.
      running_q  <= running_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      p_q        <= p_d;
      op_re_q    <= op_re_d;
      op_im_q    <= op_im_d;
      start_op_q <= start_op_d;
      op_idx_q   <= op_idx_d;
      if (active) begin
        dl_re_q[0] <= push_re;
        dl_im_q[0] <= push_im;
        for (int i = 1; i < D; i++) begin
          dl_re_q[i] <= dl_re_q[i-1];
          dl_im_q[i] <= dl_im_q[i-1];
        end
      end
    end
  end

  assign op_re    = op_re_q;
  assign op_im    = op_im_q;
  assign start_op = start_op_q;
  assign op_idx   = op_idx_q;

endmodule

// File: tb/tb_r2sdf_bf_stage.sv
// -----------------------------------------------------------------------------
// tb_r2sdf_bf_stage
//
// Four stages with N=3: u_s1 -> u_s2 -> u_s3 form a full 8-point FFT chain and
// u_solo is a stand-alone STAGE=3 fed with the same input as u_s1. A frame-level
// reference model (circular-buffer delay, per-stage counters) predicts every
// output each cycle; directed scenarios add fixed expected values.
// -----------------------------------------------------------------------------
module tb_r2sdf_bf_stage;

  logic clk;
  logic rst;
  logic start_ip;
  logic signed [15:0] ip_re, ip_im;

  logic [1:0]         tw_idx_1, tw_idx_2, tw_idx_3, tw_idx_4;
  logic signed [15:0] tw_re_1, tw_im_1, tw_re_2, tw_im_2;
  logic signed [15:0] tw_re_3, tw_im_3, tw_re_4, tw_im_4;
  logic signed [15:0] op_re_1, op_im_1, op_re_2, op_im_2;
  logic signed [15:0] op_re_3, op_im_3, op_re_4, op_im_4;
  logic               start_op_1, start_op_2, start_op_3, start_op_4;
  logic [2:0]         op_idx_1, op_idx_2, op_idx_3, op_idx_4;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] tw1_seen;

  // Twiddle ROM for N=3: {cos(2*pi*e/8), -sin(2*pi*e/8)} scaled by 2^14.
  function automatic logic [31:0] tw_word(input logic [1:0] e);
    case (e)
      2'd0:    return {16'sd16384, 16'sd0};
      2'd1:    return {16'sd11585, -16'sd11585};
      2'd2:    return {16'sd0, -16'sd16384};
      default: return {-16'sd11585, -16'sd11585};
    endcase
  endfunction

  assign {tw_re_1, tw_im_1} = tw_word(tw_idx_1);
  assign {tw_re_2, tw_im_2} = tw_word(tw_idx_2);
  assign {tw_re_3, tw_im_3} = tw_word(tw_idx_3);
  assign {tw_re_4, tw_im_4} = tw_word(tw_idx_4);

  r2sdf_bf_stage #(.N(3), .STAGE(1), .DW(16), .TW(16)) u_s1 (
    .clk(clk), .rst(rst), .start_ip(start_ip), .ip_re(ip_re), .ip_im(ip_im),
    .tw_idx(tw_idx_1), .tw_re(tw_re_1), .tw_im(tw_im_1),
    .op_re(op_re_1), .op_im(op_im_1), .start_op(start_op_1), .op_idx(op_idx_1));

  r2sdf_bf_stage #(.N(3), .STAGE(2), .DW(16), .TW(16)) u_s2 (
    .clk(clk), .rst(rst), .start_ip(start_op_1), .ip_re(op_re_1), .ip_im(op_im_1),
    .tw_idx(tw_idx_2), .tw_re(tw_re_2), .tw_im(tw_im_2),
    .op_re(op_re_2), .op_im(op_im_2), .start_op(start_op_2), .op_idx(op_idx_2));

  r2sdf_bf_stage #(.N(3), .STAGE(3), .DW(16), .TW(16)) u_s3 (
    .clk(clk), .rst(rst), .start_ip(start_op_2), .ip_re(op_re_2), .ip_im(op_im_2),
    .tw_idx(tw_idx_3), .tw_re(tw_re_3), .tw_im(tw_im_3),
    .op_re(op_re_3), .op_im(op_im_3), .start_op(start_op_3), .op_idx(op_idx_3));

  r2sdf_bf_stage #(.N(3), .STAGE(3), .DW(16), .TW(16)) u_solo (
    .clk(clk), .rst(rst), .start_ip(start_ip), .ip_re(ip_re), .ip_im(ip_im),
    .tw_idx(tw_idx_4), .tw_re(tw_re_4), .tw_im(tw_im_4),
    .op_re(op_re_4), .op_im(op_im_4), .start_op(start_op_4), .op_idx(op_idx_4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Model 0 = stage 1, 1 = chain stage 2, 2 = chain stage 3,
  // 3 = stand-alone stage 3. Outputs hold the value registered at the last edge.
  // ---------------------------------------------------------------------------
  bit m_run  [4];
  int m_cnt  [4];
  int m_since[4];
  int m_p    [4];
  int m_ptr  [4];
  int m_dl_re[4][4];
  int m_dl_im[4][4];
  int m_ore  [4];
  int m_oim  [4];
  bit m_ost  [4];
  int m_oidx [4];

  function automatic int md(input int m);
    case (m)
      0:       return 4;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int ms(input int m);
    case (m)
      0:       return 1;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = 16'(v);
    return int'(t);
  endfunction

  function automatic int rev3(input int p);
    return ((p & 1) << 2) | (p & 2) | ((p >> 2) & 1);
  endfunction

  function automatic int cmul(input int a, input int b, input logic [31:0] w, input bit want_im);
    longint c, d, r;
    logic signed [15:0] cs, ds;
    cs = w[31:16];
    ds = w[15:0];
    c = longint'(cs);
    d = longint'(ds);
    if (want_im) r = longint'(a) * d + longint'(b) * c;
    else         r = longint'(a) * c - longint'(b) * d;
    return wrap16(int'(r >>> 14));
  endfunction

  function automatic int exp_tw(input int m, input bit s);
    int c;
    c = s ? 0 : m_cnt[m];
    return (c < md(m)) ? (c << (ms(m) - 1)) : 0;
  endfunction

  task automatic mstep(input int m, input bit r, input bit s, input int ire, input int iim);
    int d, c, fre, fim, pre, pim, pidx;
    logic [31:0] w;
    d = md(m);
    if (r) begin
      m_run[m] = 1'b0; m_cnt[m] = 0; m_ptr[m] = 0; m_p[m] = 0; m_since[m] = 1000;
      for (int k = 0; k < 4; k++) begin
        m_dl_re[m][k] = 0;
        m_dl_im[m][k] = 0;
      end
      m_ore[m] = 0; m_oim[m] = 0; m_ost[m] = 1'b0; m_oidx[m] = 0;
    end else if (!m_run[m] && !s) begin
      m_ore[m] = 0; m_oim[m] = 0; m_ost[m] = 1'b0; m_oidx[m] = 0;
    end else begin
      m_run[m]   = 1'b1;
      c          = s ? 0 : m_cnt[m];
      m_since[m] = s ? 0 : m_since[m] + 1;
      fre = m_dl_re[m][m_ptr[m]];
      fim = m_dl_im[m][m_ptr[m]];
      if (c < d) begin
        w        = tw_word(2'(c << (ms(m) - 1)));
        m_ore[m] = cmul(fre, fim, w, 1'b0);
        m_oim[m] = cmul(fre, fim, w, 1'b1);
        pre = ire;
        pim = iim;
      end else begin
        m_ore[m] = wrap16(fre + ire);
        m_oim[m] = wrap16(fim + iim);
        pre = wrap16(fre - ire);
        pim = wrap16(fim - iim);
      end
      m_dl_re[m][m_ptr[m]] = pre;
      m_dl_im[m][m_ptr[m]] = pim;
      m_ptr[m]  = (m_ptr[m] + 1) % d;
      m_cnt[m]  = (c + 1) % (2 * d);
      m_ost[m]  = (m_since[m] == d);
      pidx      = m_ost[m] ? 0 : m_p[m];
      m_p[m]    = (pidx + 1) % 8;
      m_oidx[m] = rev3(pidx);
    end
  endtask

  // One clock cycle: drive at the falling edge, check twiddle address before
  // the rising edge, advance the model, compare registered outputs at the next
  // falling edge.
  task automatic tick(input bit r, input bit s, input logic signed [15:0] re,
                      input logic signed [15:0] im);
    rst = r; start_ip = s; ip_re = re; ip_im = im;
    #1;
    if (!r) begin
      tw1_seen = 32'(tw_idx_1);
      check("s1_tw", tw1_seen, 32'(exp_tw(0, s)));
      check("s2_tw", 32'(tw_idx_2), 32'(exp_tw(1, m_ost[0])));
    end
    @(posedge clk);
    mstep(2, r, m_ost[1], m_ore[1], m_oim[1]);
    mstep(1, r, m_ost[0], m_ore[0], m_oim[0]);
    mstep(0, r, s, int'(re), int'(im));
    mstep(3, r, s, int'(re), int'(im));
    @(negedge clk);
    check("s1_op",   {op_re_1, op_im_1}, {16'(m_ore[0]), 16'(m_oim[0])});
    check("s1_ctl",  32'({start_op_1, op_idx_1}), 32'({m_ost[0], 3'(m_oidx[0])}));
    check("s2_op",   {op_re_2, op_im_2}, {16'(m_ore[1]), 16'(m_oim[1])});
    check("s3_op",   {op_re_3, op_im_3}, {16'(m_ore[2]), 16'(m_oim[2])});
    check("s3_ctl",  32'({start_op_3, op_idx_3}), 32'({m_ost[2], 3'(m_oidx[2])}));
    check("solo_op", {op_re_4, op_im_4}, {16'(m_ore[3]), 16'(m_oim[3])});
    check("solo_ctl", 32'({start_op_4, op_idx_4}), 32'({m_ost[3], 3'(m_oidx[3])}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic signed [15:0] t4_in [8];
    t4_in = '{16'sd100, 16'sd30, 16'sd50, 16'sd10, 16'sd7, 16'sd3, 16'sd0, 16'sd0};
    rst = 1'b1; start_ip = 1'b0; ip_re = '0; ip_im = '0;
    @(negedge clk);

    // Reset state and idle behaviour.
    tick(1'b1, 1'b0, 16'sd0, 16'sd0);
    tick(1'b1, 1'b0, 16'sd0, 16'sd0);
    check("rst_op", {op_re_1, op_im_1}, 32'h0);
    check("rst_st", 32'({start_op_1, start_op_3, start_op_4}), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 16'($urandom), 16'($urandom));
      check("idle_op", {op_re_1, op_im_1}, 32'h0);
    end

    // Constant frame: sums wrap to -32768, differences are zero.
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, i == 0, (i < 8) ? 16'sd16384 : 16'sd0, 16'sd0);
      check("t1_op", {op_re_1, op_im_1}, {((i >= 4) && (i < 8)) ? 16'h8000 : 16'h0000, 16'h0000});
      check("t1_st", 32'(start_op_1), 32'(i == 4));
    end

    // Impulse: sums then differences rotated by W^0..W^3.
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, i == 0, (i == 0) ? 16'sd16384 : 16'sd0, 16'sd0);
      if (i < 4 || i >= 8) check("t2_tw", tw1_seen, 32'(i % 4));
      if (i >= 4) check("t2_op", {op_re_1, op_im_1}, {((i % 4) == 0) ? 16'sd16384 : 16'sd0, 16'sd0});
    end

    // Sample at x1: second difference goes through W^1.
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, i == 0, (i == 1) ? 16'sd16384 : 16'sd0, 16'sd0);
      if (i == 9) check("t3_w1", {op_re_1, op_im_1}, {16'sd11585, -16'sd11585});
    end

    // Last-stage behaviour, D=1.
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, i == 0, (i < 8) ? t4_in[i] : 16'sd0, 16'sd0);
      if (i == 1) check("t4_sum", {op_re_4, op_im_4}, {16'sd130, 16'sd0});
      if (i == 2) check("t4_diff", {op_re_4, op_im_4}, {16'sd70, 16'sd0});
      if (i >= 1 && i <= 8) begin
        check("t4_idx", 32'(op_idx_4), 32'(rev3(i - 1)));
        check("t4_st", 32'(start_op_4), 32'(i == 1));
      end
    end

    // Full chain, impulse 1024: every bin equals 1024.
    for (int i = 0; i < 18; i++) begin
      tick(1'b0, i == 0, (i == 0) ? 16'sd1024 : 16'sd0, 16'sd0);
      if (i >= 9 && i <= 16) begin
        check("t5_op", {op_re_3, op_im_3}, {16'sd1024, 16'sd0});
        check("t5_ctl", 32'({start_op_3, op_idx_3}), 32'({i == 9, 3'(rev3(i - 9))}));
      end
    end

    // Reset mid-frame.
    for (int i = 0; i < 6; i++) tick(1'b0, i == 0, 16'($urandom), 16'($urandom));
    tick(1'b1, 1'b0, 16'($urandom), 16'($urandom));
    check("t6_rst_op", {op_re_1, op_im_1}, 32'h0);
    check("t6_rst_chain", {op_re_3, op_im_3}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 16'($urandom), 16'($urandom));
      check("t6_idle_st", 32'({start_op_1, start_op_3, start_op_4}), 32'h0);
      check("t6_idle_op", {op_re_1, op_im_1}, 32'h0);
    end

    // Reset together with start: reset wins.
    tick(1'b1, 1'b1, 16'($urandom), 16'($urandom));
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, 16'($urandom), 16'($urandom));
      check("t6_rs_st", 32'({start_op_1, start_op_4}), 32'h0);
      check("t6_rs_op", {op_re_4, op_im_4}, 32'h0);
    end

    // Mid-frame resync restarts the counter.
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, (i == 0) || (i == 3), 16'($urandom), 16'($urandom));
      check("t6_resync_st", 32'(start_op_1), 32'(i == 7));
    end

    // Random frames with one extra resync, then drain.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 8; i++) begin
        tick(1'b0, (i == 0) || (f == 3 && i == 5), 16'($urandom), 16'($urandom));
      end
    end
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 16'($urandom), 16'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/r2sdf_bf_stage.md
Name: r2sdf_bf_stage

Overview:
- One pipelined radix-2 single-delay-feedback (R2SDF, decimation-in-frequency) butterfly stage for a 2^N-point streaming complex FFT.
- Accepts one complex sample per clock. N instances chained (stage 1 to N, each start_op feeding the next start_ip) form the full FFT.
- Includes the bit-reversed output index generator, so the last stage tags each output with its frequency bin.
- Twiddle factors come from an external ROM addressed by this block.

Parameters:
- N, 3, log2 of FFT size (N>=1).
- STAGE, 1, stage number n, 1..N. Delay depth D = 2^(N-STAGE).
- DW, 16, signed two's-complement width of each real/imag data word.
- TW, 16, signed twiddle word width; TW-2 fractional bits, so 1.0 = 2^(TW-2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- start_ip  in  1  pulse marking the first sample of an input frame.
- ip_re / ip_im  in  DW each  input sample.
- tw_idx  out  N-1  twiddle ROM address e; combinational from the counter.
- tw_re / tw_im  in  TW each  cos(2πe/2^N) and -sin(2πe/2^N); combinational return for tw_idx in the same cycle.
- op_re / op_im  out  DW each  registered output sample.
- start_op  out  1  registered; high with the first output sample of a frame.
- op_idx  out  N  registered; bit-reverse of the output position p.

Behaviour:
- Reset (rst high at an edge):
  - op_re, op_im, start_op, op_idx go to 0.
  - cnt, p and the delay line are cleared.
  - The running flag is cleared.
  - Reset wins over a simultaneous start_ip.
- Idle (running=0): outputs hold 0 and the delay line is not written.
- Start: start_ip sampled high sets running=1 and cnt=0 for that sample. start_ip mid-frame resynchronises cnt to 0; delay contents are kept.
- Counter: cnt runs modulo 2D. When running, it increments every cycle; frames are contiguous and there is no input-valid qualifier.
- Delay line: D-entry complex FIFO. Each running cycle it pops its oldest entry f and pushes one new entry.
  - cnt<D (fill phase):
    - push ip.
    - output f*W, where W is the twiddle for tw_idx = (cnt) * 2^(STAGE-1).
    - This emits the previous frame's differences.
  - cnt>=D (butterfly phase):
    - output f+ip.
    - push f-ip.
    - tw_idx = 0.
- Arithmetic:
  - Add and subtract wrap modulo 2^DW; no scaling, no saturation.
  - Complex multiply: re = (a·c - b·d) >>> (TW-2), im = (a·d + b·c) >>> (TW-2).
  - Products use full precision; the shift is arithmetic (floor); the result is truncated to DW bits.
  - The multiply applies to every fill-phase output, including tw_idx=0 (W=1.0, giving an exact pass-through).
- Latency:
  - If start_ip is sampled at edge E0, start_op is high in the cycle after edge E_D, i.e. D cycles later.
  - op at that point = x0 + x_D.
  - For STAGE=N (D=1), start_op follows start_ip by 1 cycle.
- Output position:
  - p resets to 0 when start_op is asserted and increments mod 2^N each running cycle.
  - op_idx = bit-reverse of the N-bit p, registered alongside op.
  - op_idx is meaningful as a frequency bin only at STAGE=N.
- Stream end: after the last frame the counter keeps running and drains the differences using whatever ip is present.
- Delay implementation: registers, shift register or RAM; behaviour must match the above exactly.

Test Plan:
1. N=3, STAGE=1, DW=16, TW=16. Reset, then start_ip with frame x = 16384 real ×8. Expect:
   - start_op 4 cycles later.
   - op_re sequence 32768 wrapped (= -32768) ×4, then 0 ×4.
   - All op_im = 0.
2. Same config, impulse x=[16384,0,…,0]. Expect:
   - op_re 16384,0,0,0 (sums).
   - Then 16384,0,0,0 (differences through twiddle W^0..W^3).
   - tw_idx sequence 0,1,2,3 during the fill phase.
3. Twiddle rounding, STAGE=1, x=[0,16384,0,…]. Expect:
   - Second difference output = (11585, -11585), given ROM entries tw_re=11585, tw_im=-11585 at e=1.
4. STAGE=3 (D=1). Input pairs (100,0),(30,0). Expect:
   - start_op 1 cycle later.
   - Outputs (130,0) then (70,0).
   - op_idx 0,4,2,6,1,5,3,7 across a frame.
5. Three-stage chain N=3, impulse 1024 at x0. Expect all eight outputs = (1024,0), with op_idx in bit-reversed order.
6. Reset and resync:
   - Assert rst mid-frame: outputs 0 the next cycle; no start_op until a new start_ip.
   - rst together with start_ip: reset wins.
   - start_ip re-pulsed mid-frame: cnt restarts at 0.
